mips_fetch_unit: RTL and testbench

- Fetch stage of the MIPS core. Directly upstream of the controller: supplies the current instruction, whose op and Funct fields go to the controller.
- Consumes the controller's Branch and Jump outputs, plus the ALU Zero flag, to choose the next PC.
- Owns the PC register, a req/ack instruction-memory handshake, the instruction hold register and a retired-instruction counter.

---
 rtl/mips_fetch_unit.sv | 100 ++++++++++
 tb/tb_mips_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: owns the PC, a single-outstanding req/ack fetch to instruction memory,
// the held instruction register and a retired-instruction counter.
module mips_fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        Funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero,
    input  logic              instr_done,
    input  logic              stall,
    output logic [31:0]       retire_cnt
);

    typedef enum logic [0:0] {StFetch, StExec} state_e;

    localparam logic [ADDR_W-1:0] ResetPcAligned = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] PcStep         = ADDR_W'(4);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic [31:0]       retire_cnt_q;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] jump_tgt;
    logic              retire;

    assign pc_inc = pc_q + PcStep;
    assign retire = (state_q == StExec) && instr_done && !stall;

    // Next PC; Jump outranks a taken branch. Jump keeps the upper bits of pc + 4.
    always_comb begin
        branch_off     = {{(ADDR_W - 18){instr_q[15]}}, instr_q[15:0], 2'b00};
        jump_tgt       = pc_inc;
        jump_tgt[27:0] = {instr_q[25:0], 2'b00};
        pc_d           = pc_inc;
        if (Jump) begin
            pc_d = jump_tgt;
        end else if (Branch && Zero) begin
            pc_d = pc_inc + branch_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            pc_q          <= ResetPcAligned;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StExec;
                    end
                end
                StExec: begin
                    if (retire) begin
                        pc_q          <= pc_d;
                        retire_cnt_q  <= retire_cnt_q + 32'd1;
                        instr_valid_q <= 1'b0;
                        state_q       <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    // Request is gated by rst_n so it drops the instant reset is asserted.
    assign imem_req    = rst_n && (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_inc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign op          = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: accepted fetch addresses are checked against a queue of expected
// addresses; each scenario task also compares PC, instruction and counter state inline.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Branch, Jump, Zero, instr_done, stall;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retire_cnt;
    logic [5:0]  op, Funct;

    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus42, retire_cnt2;
    logic [5:0]  op2, Funct2;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_addr_q[$];

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .op(op), .Funct(Funct), .pc(pc), .pc_plus4(pc_plus4),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .instr_done(instr_done),
        .stall(stall), .retire_cnt(retire_cnt)
    );

    // Second instance with a high, misaligned reset PC; runs in lockstep on shared inputs.
    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h8000_0013)) dut_hi (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid2),
        .instr(instr2), .op(op2), .Funct(Funct2), .pc(pc2), .pc_plus4(pc_plus42),
        .Branch(Branch), .Jump(Jump), .Zero(Zero), .instr_done(instr_done),
        .stall(stall), .retire_cnt(retire_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every fetch that will be accepted on the coming edge must match the next expected address.
    always @(negedge clk) begin
        if (rst_n && imem_req && imem_ack) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got addr %h, required no fetch", imem_addr);
            end else begin
                automatic logic [31:0] e = exp_addr_q.pop_front();
                if (imem_addr !== e) begin
                    errors++;
                    $display("FAIL fetch_addr: got %h, required %h", imem_addr, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        Branch     = 1'b0;
        Jump       = 1'b0;
        Zero       = 1'b0;
        instr_done = 1'b0;
        stall      = 1'b0;
    endtask

    task automatic apply_reset();
        tick();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0
            || retire_cnt !== 32'h0 || op !== 6'h0 || Funct !== 6'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b pc=%h instr=%h valid=%b cnt=%0d, required 0s",
                     imem_req, pc, instr, instr_valid, retire_cnt);
        end
        checks++;
        if (pc2 !== 32'h8000_0010) begin
            errors++;
            $display("FAIL reset_pc_align: got %h, required 80000010", pc2);
        end
        tick();
        rst_n = 1'b1;
    endtask

    // ack and instr_done tied high: one instruction every two cycles.
    task automatic test_streaming();
        imem_ack   = 1'b1;
        instr_done = 1'b1;
        imem_rdata = 32'h2008_0005;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(4 * i));
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (instr_valid !== ((k % 2) == 1)) begin
                errors++;
                $display("FAIL stream_valid cycle %0d: got %b, required %b", k, instr_valid,
                         (k % 2) == 1);
            end
            if (k == 1) begin
                checks++;
                if (instr !== 32'h2008_0005 || op !== 6'h08 || Funct !== 6'h05) begin
                    errors++;
                    $display("FAIL stream_instr: got %h op %h funct %h, required 20080005 08 05",
                             instr, op, Funct);
                end
            end
        end
        idle_inputs();
        checks++;
        if (retire_cnt !== 32'd4 || pc !== 32'h10 || pc_plus4 !== 32'h14) begin
            errors++;
            $display("FAIL stream_count: cnt %0d pc %h pc4 %h, required 4 10 14",
                     retire_cnt, pc, pc_plus4);
        end
    endtask

    task automatic test_ack_delay();
        apply_reset();
        imem_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0
                || instr !== 32'h0) begin
                errors++;
                $display("FAIL ack_wait cycle %0d: req %b addr %h valid %b instr %h", k,
                         imem_req, imem_addr, instr_valid, instr);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0123_4567;
        exp_addr_q.push_back(32'h0);
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h0123_4567 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_latch: valid %b instr %h req %b, required 1 01234567 0",
                     instr_valid, instr, imem_req);
        end
        // ack in EXEC must be ignored
        imem_rdata = 32'hFFFF_FFFF;
        tick();
        checks++;
        if (instr !== 32'h0123_4567 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL exec_ignore_ack: instr %h valid %b, required 01234567 1",
                     instr, instr_valid);
        end
        idle_inputs();
        instr_done = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h4 || retire_cnt !== 32'd1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_retire: pc %h cnt %0d valid %b, required 4 1 0",
                     pc, retire_cnt, instr_valid);
        end
    endtask

    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word);
        idle_inputs();
        imem_ack   = 1'b1;
        imem_rdata = word;
        exp_addr_q.push_back(addr);
        tick();
        idle_inputs();
    endtask

    task automatic retire_with(input logic br, input logic jp, input logic zr);
        Branch     = br;
        Jump       = jp;
        Zero       = zr;
        instr_done = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_branch();
        apply_reset();
        fetch_word(32'h0, 32'h0800_0010);
        retire_with(1'b0, 1'b1, 1'b0);
        checks++;
        if (imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL jump_low: got %h, required 00000040", imem_addr);
        end
        fetch_word(32'h40, 32'h1000_FFFE);
        checks++;
        if (op !== 6'h04 || Funct !== 6'h3E) begin
            errors++;
            $display("FAIL branch_fields: op %h funct %h, required 04 3e", op, Funct);
        end
        retire_with(1'b1, 1'b0, 1'b1);
        checks++;
        if (imem_addr !== 32'h3C || pc_plus4 !== 32'h40) begin
            errors++;
            $display("FAIL branch_taken: addr %h pc4 %h, required 3c 40", imem_addr, pc_plus4);
        end
        fetch_word(32'h3C, 32'h0800_0010);
        retire_with(1'b0, 1'b1, 1'b0);
        fetch_word(32'h40, 32'h1000_FFFE);
        retire_with(1'b1, 1'b0, 1'b0);
        checks++;
        if (imem_addr !== 32'h44 || retire_cnt !== 32'd4) begin
            errors++;
            $display("FAIL branch_not_taken: addr %h cnt %0d, required 44 4",
                     imem_addr, retire_cnt);
        end
    endtask

    task automatic test_jump_priority();
        apply_reset();
        fetch_word(32'h0, 32'h0800_0100);
        retire_with(1'b1, 1'b1, 1'b1);
        checks++;
        if (imem_addr2 !== 32'h8000_0400) begin
            errors++;
            $display("FAIL jump_high: got %h, required 80000400", imem_addr2);
        end
        checks++;
        if (imem_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL jump_over_branch: got %h, required 00000400", imem_addr);
        end
    endtask

    task automatic test_stall();
        fetch_word(32'h400, 32'h2008_0005);
        stall      = 1'b1;
        instr_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (pc !== 32'h400 || instr !== 32'h2008_0005 || retire_cnt !== 32'd1
                || instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: pc %h instr %h cnt %0d valid %b", k,
                         pc, instr, retire_cnt, instr_valid);
            end
        end
        stall = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h404 || retire_cnt !== 32'd2 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: pc %h cnt %0d valid %b, required 404 2 0",
                     pc, retire_cnt, instr_valid);
        end
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset();
        fetch_word(32'h0, 32'h0800_0008);
        retire_with(1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20 || retire_cnt !== 32'd1) begin
            errors++;
            $display("FAIL pre_reset: req %b addr %h cnt %0d, required 1 20 1",
                     imem_req, imem_addr, retire_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || retire_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: req %b pc %h cnt %0d, required 0 0 0",
                     imem_req, pc, retire_cnt);
        end
        tick();
        rst_n = 1'b1;
        fetch_word(32'h0, 32'h2008_0005);
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("FAIL refetch_after_reset: instr %h valid %b pc %h, required 20080005 1 0",
                     instr, instr_valid, pc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_streaming();
        test_ack_delay();
        test_branch();
        test_jump_priority();
        test_stall();
        test_reset_mid_fetch();
        tick();
        checks++;
        if (exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL fetch_missing: %0d expected fetches never seen, required 0",
                     exp_addr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
